// File: rtl/wb_write_queue.sv
// wb_write_queue: two-source (load/ALU) in-order writeback queue driving the register file write port
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_rd,
  input  logic [31:0]              ld_data,
  output logic                     ld_ready,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  output logic [4:0]               A3,
  output logic [31:0]              WD,
  output logic                     We,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);
  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, off;
  logic          ld_push, alu_push, pop;
  assign ld_ready  = !rst && (count < FULL);
  assign alu_ready = !rst && ((count < ALMOST) || ((count < FULL) && !ld_valid));
  // rd==0 results complete the handshake but are dropped (x0 is never written)
  assign ld_push  = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign pop      = count != '0;
  assign We = pop;
  assign A3 = pop ? mem_rd[rd_ptr] : 5'd0;
  assign WD = pop ? mem_data[rd_ptr] : 32'd0;
  always_comb begin
    pending = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if ({1'b0, off} < count) pending = pending | (32'd1 << mem_rd[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(ld_push) + AW'(alu_push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
    end
  end
  // load takes the first free slot, ALU the one after it
  always_ff @(posedge clk) begin
    if (ld_push) begin
      mem_rd[wr_ptr]   <= ld_rd;
      mem_data[wr_ptr] <= ld_data;
    end
    if (alu_push) begin
      mem_rd[wr_ptr + AW'(ld_push)]   <= alu_rd;
      mem_data[wr_ptr + AW'(ld_push)] <= alu_data;
    end
  end
endmodule
